// File: rtl/switch_alloc.sv
// switch_alloc: 5x5 wormhole switch allocator with one IDLE/LOCKED FSM and owner per output.
// Define SA_FIXED_PRIO_EN for fixed priority (input 1 highest); the default build is round-robin.
module switch_alloc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_port_addr1_i,
  input  logic [2:0] req_port_addr2_i,
  input  logic [2:0] req_port_addr3_i,
  input  logic [2:0] req_port_addr4_i,
  input  logic [2:0] req_port_addr5_i,
  input  logic [4:0] req_valid_i,
  input  logic [4:0] tail_i,
  input  logic [4:0] out_ready_i,
  output logic [4:0] pop_o,
  output logic [4:0] out_valid_o,
  output logic [2:0] sel_north_o,
  output logic [2:0] sel_south_o,
  output logic [2:0] sel_east_o,
  output logic [2:0] sel_west_o,
  output logic [2:0] sel_local_o,
  output logic       bad_req_o
);

  localparam int         NP       = 5;
  localparam logic [2:0] SEL_NONE = 3'd7;
  localparam logic [2:0] MAX_CODE = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  logic [2:0]    code    [NP];
  state_e        state_q [NP];
  state_e        state_d [NP];
  logic [2:0]    owner_q [NP];
  logic [2:0]    owner_d [NP];
  logic [2:0]    rr_q    [NP];
  logic [2:0]    rr_d    [NP];
  logic [2:0]    sel     [NP];
  logic [NP-1:0] req_mat [NP];  // req_mat[p][k]: input k requests output p
  logic [NP-1:0] owns;
  logic          bad_req_q;
  logic          bad_req_d;

  assign code[0] = req_port_addr1_i;
  assign code[1] = req_port_addr2_i;
  assign code[2] = req_port_addr3_i;
  assign code[3] = req_port_addr4_i;
  assign code[4] = req_port_addr5_i;

`ifdef SA_FIXED_PRIO_EN
  function automatic logic [2:0] pick(input logic [NP-1:0] reqs, input logic [2:0] rr);
    logic [2:0] win;
    win = 3'd0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (reqs[i]) win = 3'(i);
    end
    return win;
  endfunction
`else
  // Cyclic search starting one past the last winner, so the last winner ranks lowest.
  function automatic logic [2:0] pick(input logic [NP-1:0] reqs, input logic [2:0] rr);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    idx   = rr;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < NP; i++) begin
      idx = (idx >= MAX_CODE) ? 3'd0 : idx + 3'd1;
      if (!found && reqs[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction
`endif

  // An input holding any output may not request another, keeping pop_o one-hot per input.
  always_comb begin
    owns = '0;
    for (int p = 0; p < NP; p++) begin
      if (state_q[p] == ST_LOCKED) owns[owner_q[p]] = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    bad_req_d = bad_req_q;
    for (int p = 0; p < NP; p++) req_mat[p] = '0;
    for (int k = 0; k < NP; k++) begin
      if (req_valid_i[k] && (code[k] > MAX_CODE)) bad_req_d = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (req_valid_i[k] && (code[k] == 3'(p)) && !owns[k]) req_mat[p][k] = 1'b1;
      end
    end
  end

  // Grants only come from IDLE, so an output released this cycle re-arbitrates next cycle.
  always_comb begin
    pop_o       = '0;
    out_valid_o = '0;
    for (int p = 0; p < NP; p++) begin
      state_d[p] = state_q[p];
      owner_d[p] = owner_q[p];
      rr_d[p]    = rr_q[p];
      sel[p]     = SEL_NONE;
      case (state_q[p])
        ST_IDLE: begin
          if (|req_mat[p]) begin
            owner_d[p] = pick(req_mat[p], rr_q[p]);
            state_d[p] = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          sel[p] = owner_q[p];
          if (req_valid_i[owner_q[p]] && out_ready_i[p]) begin
            out_valid_o[p]       = 1'b1;
            pop_o[owner_q[p]]    = 1'b1;
            if (tail_i[owner_q[p]]) begin
              state_d[p] = ST_IDLE;
              rr_d[p]    = owner_q[p];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state is reset so a mid-packet reset leaves no lock behind; rr=4 makes input 1 win first.
      for (int p = 0; p < NP; p++) begin
        state_q[p] <= ST_IDLE;
        owner_q[p] <= 3'd0;
        rr_q[p]    <= 3'd4;
      end
      bad_req_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int p = 0; p < NP; p++) begin
        state_q[p] <= state_d[p];
        owner_q[p] <= owner_d[p];
        rr_q[p]    <= rr_d[p];
      end
      bad_req_q <= bad_req_d;
    end
  end

  assign sel_north_o = sel[0];
  assign sel_south_o = sel[1];
  assign sel_east_o  = sel[2];
  assign sel_west_o  = sel[3];
  assign sel_local_o = sel[4];
  assign bad_req_o   = bad_req_q;

endmodule

// File: tb/tb_switch_alloc.sv
// Directed self-checking bench for switch_alloc; outputs are sampled on the falling edge.
// Expectations for the SA_FIXED_PRIO_EN build are selected with the same macro.
module tb_switch_alloc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_port_addr1_i, req_port_addr2_i, req_port_addr3_i;
  logic [2:0] req_port_addr4_i, req_port_addr5_i;
  logic [4:0] req_valid_i, tail_i, out_ready_i;
  logic [4:0] pop_o, out_valid_o;
  logic [2:0] sel_north_o, sel_south_o, sel_east_o, sel_west_o, sel_local_o;
  logic       bad_req_o;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [14:0] NS = 15'h7FFF;

  logic [14:0] v_addr [16];
  logic [4:0]  v_val  [16];
  logic [4:0]  v_tail [16];
  logic [4:0]  v_rdy  [16];
  logic [25:0] v_exp  [16];
  logic [25:0] got;

  always #5 clk = ~clk;

  switch_alloc dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_port_addr1_i (req_port_addr1_i),
    .req_port_addr2_i (req_port_addr2_i),
    .req_port_addr3_i (req_port_addr3_i),
    .req_port_addr4_i (req_port_addr4_i),
    .req_port_addr5_i (req_port_addr5_i),
    .req_valid_i      (req_valid_i),
    .tail_i           (tail_i),
    .out_ready_i      (out_ready_i),
    .pop_o            (pop_o),
    .out_valid_o      (out_valid_o),
    .sel_north_o      (sel_north_o),
    .sel_south_o      (sel_south_o),
    .sel_east_o       (sel_east_o),
    .sel_west_o       (sel_west_o),
    .sel_local_o      (sel_local_o),
    .bad_req_o        (bad_req_o)
  );

  // Field 0 = input 1 / north ... field 4 = input 5 / local.
  function automatic logic [14:0] pk5(input logic [2:0] x0, x1, x2, x3, x4);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [14:0] sel1(input int p, input logic [2:0] o);
    logic [14:0] s;
    s = NS;
    s[3*p +: 3] = o;
    return s;
  endfunction

  function automatic logic [25:0] ex(input logic [4:0] pop, ov, input logic [14:0] sel, input logic bad);
    return {pop, ov, sel, bad};
  endfunction

  function automatic logic [25:0] observe();
    return {pop_o, out_valid_o, sel_local_o, sel_west_o, sel_east_o, sel_south_o, sel_north_o, bad_req_o};
  endfunction

  task automatic drive(input logic [14:0] a, input logic [4:0] v, t, r);
    req_port_addr1_i = a[2:0];
    req_port_addr2_i = a[5:3];
    req_port_addr3_i = a[8:6];
    req_port_addr4_i = a[11:9];
    req_port_addr5_i = a[14:12];
    req_valid_i      = v;
    tail_i           = t;
    out_ready_i      = r;
  endtask

  task automatic set_vec(input int i, input logic [14:0] a, input logic [4:0] v, t, r,
                         input logic [25:0] e);
    v_addr[i] = a;
    v_val[i]  = v;
    v_tail[i] = t;
    v_rdy[i]  = r;
    v_exp[i]  = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive('0, '0, '0, '0);
    @(posedge clk); #1;
    drive(pk5(0, 0, 0, 0, 6), 5'b11111, 5'b11111, 5'b11111);
    @(negedge clk);
    got = observe();
    n_cmp++;
    if (got !== ex(0, 0, NS, 0)) begin
      n_mis++;
      $display("FAIL reset_async: got %h expected %h", got, ex(0, 0, NS, 0));
    end
    @(negedge clk);
    got = observe();
    n_cmp++;
    if (got !== ex(0, 0, NS, 0)) begin
      n_mis++;
      $display("FAIL reset_held: got %h expected %h", got, ex(0, 0, NS, 0));
    end
    @(posedge clk); #1;
    drive('0, '0, '0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int wa, wb;
`ifdef SA_FIXED_PRIO_EN
    wa = 0; wb = 0;
`else
    wa = 2; wb = 3;
`endif
    set_vec(0, pk5(2, 0, 2, 0, 0), 5'b00101, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(1, pk5(2, 0, 2, 0, 0), 5'b00101, 5'b00000, 5'b11111, ex(5'b00001, 5'b00100, sel1(2, 0), 0));
    set_vec(2, pk5(2, 0, 2, 0, 0), 5'b00101, 5'b00001, 5'b11111, ex(5'b00001, 5'b00100, sel1(2, 0), 0));
    set_vec(3, pk5(2, 0, 2, 0, 0), 5'b00101, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(4, pk5(2, 0, 2, 0, 0), 5'b00101, 5'b11111, 5'b11111,
            ex(5'(1 << wa), 5'b00100, sel1(2, 3'(wa)), 0));
    set_vec(5, pk5(2, 0, 2, 2, 0), 5'b01101, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(6, pk5(2, 0, 2, 2, 0), 5'b01101, 5'b11111, 5'b11111,
            ex(5'(1 << wb), 5'b00100, sel1(2, 3'(wb)), 0));
    set_vec(7, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    for (int i = 0; i < 8; i++) begin
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL round_robin_east cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [25:0] xf, st;
    xf = ex(5'b00010, 5'b10000, sel1(4, 1), 0);
    st = ex(5'b00000, 5'b00000, sel1(4, 1), 0);
    set_vec(0, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(1, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00000, 5'b11111, xf);
    set_vec(2, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00000, 5'b01111, st);
    set_vec(3, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00000, 5'b01111, st);
    set_vec(4, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00000, 5'b11111, xf);
    set_vec(5, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00000, 5'b11111, xf);
    set_vec(6, pk5(0, 4, 0, 0, 0), 5'b00010, 5'b00010, 5'b11111, xf);
    set_vec(7, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    for (int i = 0; i < 8; i++) begin
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL stall_local cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_parallel();
    set_vec(0, pk5(4, 0, 3, 1, 2), 5'b11111, 5'b11111, 5'b11111, ex(0, 0, NS, 0));
    set_vec(1, pk5(4, 0, 3, 1, 2), 5'b11111, 5'b11111, 5'b11111,
            ex(5'b11111, 5'b11111, pk5(1, 3, 4, 2, 0), 0));
    set_vec(2, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    for (int i = 0; i < 3; i++) begin
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL parallel cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_req();
    set_vec(0, pk5(0, 0, 0, 0, 6), 5'b10000, 5'b10000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(1, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 1));
    set_vec(2, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 1));
    for (int i = 0; i < 3; i++) begin
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL bad_req cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    set_vec(0, '0, 5'b00001, 5'b00000, 5'b11111, ex(0, 0, NS, 1));
    set_vec(1, '0, 5'b00001, 5'b00000, 5'b11111, ex(5'b00001, 5'b00001, sel1(0, 0), 1));
    set_vec(2, '0, 5'b00001, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(3, '0, 5'b00011, 5'b00011, 5'b11111, ex(0, 0, NS, 0));
    set_vec(4, '0, 5'b00011, 5'b00011, 5'b11111, ex(5'b00001, 5'b00001, sel1(0, 0), 0));
    set_vec(5, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    for (int i = 0; i < 6; i++) begin
      rst_n = (i == 2) ? 1'b0 : 1'b1;
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL mid_reset cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [25:0] xf;
    xf = ex(5'b01000, 5'b01000, sel1(3, 3), 0);
    set_vec(0, pk5(0, 0, 0, 3, 0), 5'b01000, 5'b01000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(1, pk5(0, 0, 0, 3, 0), 5'b01000, 5'b01000, 5'b11111, xf);
    set_vec(2, pk5(0, 0, 0, 3, 0), 5'b01000, 5'b01000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(3, pk5(0, 0, 0, 3, 0), 5'b01000, 5'b01000, 5'b11111, xf);
    set_vec(4, pk5(0, 0, 0, 3, 0), 5'b01000, 5'b01000, 5'b11111, ex(0, 0, NS, 0));
    set_vec(5, pk5(0, 0, 0, 3, 0), 5'b00000, 5'b01000, 5'b11111, ex(0, 0, sel1(3, 3), 0));
    set_vec(6, pk5(0, 0, 0, 3, 0), 5'b01000, 5'b01000, 5'b11111, xf);
    set_vec(7, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    for (int i = 0; i < 8; i++) begin
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contend_north();
    int w1, w2, w3;
`ifdef SA_FIXED_PRIO_EN
    w1 = 0; w2 = 0; w3 = 0;
`else
    w1 = 1; w2 = 0; w3 = 1;
`endif
    set_vec(0, '0, 5'b00011, 5'b00011, 5'b11111, ex(0, 0, NS, 0));
    set_vec(1, '0, 5'b00011, 5'b00011, 5'b11111, ex(5'(1 << w1), 5'b00001, sel1(0, 3'(w1)), 0));
    set_vec(2, '0, 5'b00011, 5'b00011, 5'b11111, ex(0, 0, NS, 0));
    set_vec(3, '0, 5'b00011, 5'b00011, 5'b11111, ex(5'(1 << w2), 5'b00001, sel1(0, 3'(w2)), 0));
    set_vec(4, '0, 5'b00011, 5'b00011, 5'b11111, ex(0, 0, NS, 0));
    set_vec(5, '0, 5'b00011, 5'b00011, 5'b11111, ex(5'(1 << w3), 5'b00001, sel1(0, 3'(w3)), 0));
    set_vec(6, '0, 5'b00000, 5'b00000, 5'b11111, ex(0, 0, NS, 0));
    for (int i = 0; i < 7; i++) begin
      drive(v_addr[i], v_val[i], v_tail[i], v_rdy[i]);
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== v_exp[i]) begin
        n_mis++;
        $display("FAIL contend_north cyc %0d: got %h expected %h", i, got, v_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_parallel();
    test_bad_req();
    test_mid_reset();
    test_back_to_back();
    test_contend_north();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/switch_alloc.md
SWITCH_ALLOC -- requirements
Module: switch_alloc

Interface
REQ-001: Port naming, direction, width and meaning SHALL be as REQ-002 to REQ-012; one clock; reset asynchronous, active-low.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: req_port_addr1_i..req_port_addr5_i  input  3 each  requested output port of head flit, inputs 1..5 (bit index 0..4). Codes: 0 north, 1 south, 2 east, 3 west, 4 local, 5-7 illegal.
REQ-005: req_valid_i  input  5  bit k = input k+1 has a head-of-queue flit.
REQ-006: tail_i  input  5  bit k = input k+1's head-of-queue flit is a tail (a single-flit packet has tail set on its head).
REQ-007: out_ready_i  input  5  bit p = output p can accept a flit this cycle.
REQ-008: pop_o  output  5  bit k = input k+1's flit transfers this cycle; dequeue.
REQ-009: out_valid_o  output  5  bit p = output p carries a flit this cycle.
REQ-010: sel_north_o, sel_south_o, sel_east_o, sel_west_o, sel_local_o  output  3 each  crossbar select: owning input index 0..4; 7 when the output is unowned.
REQ-011: bad_req_o  output  1  sticky flag: an illegal port code was presented with its valid bit set.
REQ-012: No parameters; all widths fixed.

Function
REQ-013: Each output p SHALL run an independent two-state FSM, IDLE and LOCKED, with a 3-bit owner register and a 3-bit round-robin pointer rr_p.
REQ-014: Input k SHALL request output p when req_valid_i[k]=1, its code equals p, and input k owns no output.
REQ-015: In IDLE with one or more requesters, the output SHALL register the winner into owner and enter LOCKED at the next edge.
REQ-016: The winner SHALL be the first requester searched cyclically from rr_p+1 mod 5.
REQ-017: While in IDLE, the output SHALL hold out_valid_o[p]=0 and sel=7, and SHALL pop nothing.
REQ-018: In LOCKED, out_valid_o[p] and pop_o[owner] SHALL both be asserted combinationally, in the same cycle, when req_valid_i[owner]=1 and out_ready_i[p]=1.
REQ-019: Transfer latency SHALL be 1 cycle: a request in cycle N gives its first possible transfer in cycle N+1.
REQ-020: A transfer with tail_i[owner]=1 SHALL return the output to IDLE and set rr_p to owner at the next edge.
REQ-021: A locked output SHALL never change owner before the tail transfers (wormhole lock).
REQ-022: Minimum spacing SHALL be 2 cycles per packet per output.
REQ-023: If owner's req_valid_i drops or out_ready_i[p]=0, the output SHALL hold LOCKED and pop nothing (stall).
REQ-024: pop_o SHALL be one-hot or zero per input: an input owns at most one output.
REQ-025: Illegal codes SHALL be ignored as requests and SHALL set bad_req_o, which clears only on reset.
REQ-026: Simultaneous release of output p and a new request for p in the same cycle SHALL NOT grant in that cycle; arbitration occurs the following IDLE cycle.

Reset
REQ-027: While rst_n=0, all FSMs SHALL be IDLE, owners 0, and every rr_p=4 so that input 1 wins first.
REQ-028: While rst_n=0, pop_o=0, out_valid_o=0, all sel_*_o=7 and bad_req_o=0, effective immediately.
REQ-029: Reset asserted mid-packet SHALL abandon all locks; no partial state survives.

Configuration
REQ-030: With SA_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (input 1 highest, input 5 lowest), rr pointers unused. Without it, round-robin per REQ-016.

Verification
REQ-031: After reset, inputs 1 and 3 both request east: input 1 locked cycle 1; input 3 granted after input 1's tail and one IDLE cycle; next contention, input 3 loses to input 4 ahead of input 1.
REQ-032: 4-flit packet input 2 -> local, out_ready_i[4] low cycles 2-3: exactly 4 pops, none while out_ready_i[4] is low; sel_local_o=1 throughout; 7 after the tail.
REQ-033: Five inputs each request a distinct output in the same cycle: all five lock next cycle and transfer in parallel; pop_o=5'b11111.
REQ-034: Input 5 presents code 6 with valid: no grant, bad_req_o=1, held until rst_n low.
REQ-035: rst_n pulsed low mid-packet: outputs zero and sel=7 immediately; after release, input 1 wins the next contention.
REQ-036: Compiled with SA_FIXED_PRIO_EN, inputs 1 and 2 repeatedly contend for north: input 1 always wins.
